ptt_sequencer: RTL

PTT_SEQUENCER -- requirements
Module: ptt_sequencer

---
 rtl/ptt_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ptt_sequencer.sv
// PTT sequencer: synchronised/debounced PTT pin, T/R relay and TX enable sequencing FSM.
// Define PTT_TIMEOUT_EN to build the key-down timeout with LOCKOUT state.
module ptt_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 12000,
   parameter int unsigned TX_DELAY_CYCLES = 120000,
   parameter int unsigned RX_DELAY_CYCLES = 60000,
   parameter int unsigned TIMEOUT_TICKS   = 60000,
   parameter int unsigned MS_CYCLES       = 12000
) (
   input  logic       CLK_12MHZ,
   input  logic       nRESET,
   input  logic       OnBoard_nPTT,
   input  logic       sw_PTT,
   input  logic       PTT_enable,
   output logic       nPTT,
   output logic       TR_relay,
   output logic       TX_enable,
   output logic [2:0] state,
   output logic       timeout
);

   localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned DLY_MAX = (TX_DELAY_CYCLES > RX_DELAY_CYCLES) ? TX_DELAY_CYCLES
                                                                         : RX_DELAY_CYCLES;
   localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

   typedef enum logic [2:0] {
      ST_RX      = 3'd0,
      ST_KEYUP   = 3'd1,
      ST_TX      = 3'd2,
      ST_UNKEY   = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_e;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             req_c;
   logic             nptt_q, nptt_d;
   state_e           state_q, state_d;
   logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
   logic             lock_q, lock_d;
   logic             tr_relay_q, tr_relay_d;
   logic             tx_enable_q, tx_enable_d;
   logic             expire_c;

   // Two-flop synchroniser, then accept a new level only after it persists DEBOUNCE_CYCLES clocks
   always_comb begin
      sync1_d   = OnBoard_nPTT;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   assign req_c  = ~deb_q | sw_PTT;
   assign nptt_d = ~req_c;

   // Sequencing FSM; the delay counter only ever runs to its terminal value, then clears
   always_comb begin
      state_d   = state_q;
      dly_cnt_d = '0;
      lock_d    = lock_q | expire_c;
      unique case (state_q)
         ST_RX: begin
            lock_d = 1'b0;
            if (req_c && PTT_enable) begin
               state_d = ST_KEYUP;
            end
         end
         ST_KEYUP: begin
            if (expire_c || !req_c || !PTT_enable) begin
               state_d = ST_UNKEY;
            end else if (dly_cnt_q == DLY_W'(TX_DELAY_CYCLES - 1)) begin
               state_d = ST_TX;
            end else begin
               dly_cnt_d = dly_cnt_q + DLY_W'(1);
            end
         end
         ST_TX: begin
            if (expire_c || !req_c || !PTT_enable) begin
               state_d = ST_UNKEY;
            end
         end
         ST_UNKEY: begin
            // Re-assertion of req is ignored here; re-keying only happens from RX
            if (dly_cnt_q == DLY_W'(RX_DELAY_CYCLES - 1)) begin
               state_d = lock_q ? ST_LOCKOUT : ST_RX;
            end else begin
               dly_cnt_d = dly_cnt_q + DLY_W'(1);
            end
         end
         ST_LOCKOUT: begin
            if (!req_c) begin
               state_d = ST_RX;
            end
         end
         default: begin
            state_d = ST_RX;
         end
      endcase
   end

   assign tr_relay_d  = (state_d == ST_KEYUP) || (state_d == ST_TX) || (state_d == ST_UNKEY);
   assign tx_enable_d = (state_d == ST_TX);

   always_ff @(posedge CLK_12MHZ or negedge nRESET) begin
      if (!nRESET) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_cnt_q   <= '0;
         nptt_q      <= 1'b1;
         state_q     <= ST_RX;
         dly_cnt_q   <= '0;
         lock_q      <= 1'b0;
         tr_relay_q  <= 1'b0;
         tx_enable_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         nptt_q      <= nptt_d;
         state_q     <= state_d;
         dly_cnt_q   <= dly_cnt_d;
         lock_q      <= lock_d;
         tr_relay_q  <= tr_relay_d;
         tx_enable_q <= tx_enable_d;
      end
   end

`ifdef PTT_TIMEOUT_EN
   localparam int unsigned MS_W   = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam int unsigned TICK_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

   logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              timeout_q, timeout_d;

   // ms prescaler and key-down tick counter; frozen outside KEYUP/TX, cleared in RX
   always_comb begin
      ms_cnt_d   = ms_cnt_q;
      tick_cnt_d = tick_cnt_q;
      expire_c   = 1'b0;
      if (state_q == ST_RX) begin
         ms_cnt_d   = '0;
         tick_cnt_d = '0;
      end else if ((state_q == ST_KEYUP) || (state_q == ST_TX)) begin
         if (ms_cnt_q == MS_W'(MS_CYCLES - 1)) begin
            ms_cnt_d = '0;
            if (tick_cnt_q == TICK_W'(TIMEOUT_TICKS - 1)) begin
               expire_c = 1'b1;
            end else begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
         end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
         end
      end
   end

   assign timeout_d = (state_d == ST_LOCKOUT);

   always_ff @(posedge CLK_12MHZ or negedge nRESET) begin
      if (!nRESET) begin
         ms_cnt_q   <= '0;
         tick_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         ms_cnt_q   <= ms_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   localparam int unsigned unused_timeout_cfg = MS_CYCLES + TIMEOUT_TICKS;
   assign expire_c = 1'b0;
   assign timeout  = 1'b0;
`endif

   assign nPTT      = nptt_q;
   assign TR_relay  = tr_relay_q;
   assign TX_enable = tx_enable_q;
   assign state     = state_q;

endmodule
